// File: rtl/mc_bus_master.sv
// mc_bus_master: initiator for the asynchronous SRAM-style memory-controller bus.
// Accepts one read/write command at a time on a valid/ready interface and runs a
// SETUP -> STROBE -> HOLD bus cycle with parameterised phase lengths.
// Optional macro MC_BUS_MASTER_TURNAROUND_EN adds a 2-clock TURN state after reads
// so the responder's output drivers get extra turnaround time.
module mc_bus_master #(
    parameter int unsigned MC_DATA_WIDTH = 16,
    parameter int unsigned MC_ADD_WIDTH  = 6,
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned CNT_WIDTH     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [MC_ADD_WIDTH-1:0]  cmd_add,
    input  logic [MC_DATA_WIDTH-1:0] cmd_data,
    output logic                     rsp_valid,
    output logic [MC_DATA_WIDTH-1:0] rsp_data,
    output logic                     busy,
    output logic                     mc_ce,
    output logic                     mc_oe,
    output logic                     mc_we,
    output logic [MC_ADD_WIDTH-1:0]  mc_add,
    output logic [MC_DATA_WIDTH-1:0] mc_dout,
    output logic                     mc_dout_oe,
    input  logic [MC_DATA_WIDTH-1:0] mc_din
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
`ifdef MC_BUS_MASTER_TURNAROUND_EN
        StHold,
        StTurn
`else
        StHold
`endif
    } state_e;

    // Phase counters load N-1 on entry and the phase ends when they reach zero.
    localparam logic [CNT_WIDTH-1:0] SetupLoad  = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] StrobeLoad = CNT_WIDTH'(STROBE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HoldLoad   = CNT_WIDTH'(HOLD_CYCLES - 1);
`ifdef MC_BUS_MASTER_TURNAROUND_EN
    localparam logic [CNT_WIDTH-1:0] TurnLoad   = CNT_WIDTH'(1);
`endif

    state_e                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     write_q;
    logic [MC_ADD_WIDTH-1:0]  add_q;
    logic [MC_DATA_WIDTH-1:0] dout_q;
    logic [MC_DATA_WIDTH-1:0] rsp_data_q;
    logic                     rsp_valid_q;
    logic                     accept;
    logic                     strobe_last;
    logic                     bus_active;

    assign accept      = (state_q == StIdle) && cmd_valid;
    assign strobe_last = (state_q == StStrobe) && (cnt_q == '0);

    // State and phase counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: each bus phase runs for its programmed number of clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StSetup;
                    cnt_d   = SetupLoad;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StStrobe;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
`ifdef MC_BUS_MASTER_TURNAROUND_EN
                    if (!write_q) begin
                        state_d = StTurn;
                        cnt_d   = TurnLoad;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MC_BUS_MASTER_TURNAROUND_EN
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Command capture and read-data sampling on the edge that ends the strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q     <= 1'b0;
            add_q       <= '0;
            dout_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                write_q <= cmd_write;
                add_q   <= cmd_add;
                // mc_dout keeps the last write data; read commands carry none.
                if (cmd_write) begin
                    dout_q <= cmd_data;
                end
            end
            if (strobe_last && !write_q) begin
                rsp_data_q  <= mc_din;
                rsp_valid_q <= 1'b1;
            end
        end
    end

    // Bus outputs decode straight from state so an async reset releases them at once.
    always_comb begin
        bus_active = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
        cmd_ready  = (state_q == StIdle);
        busy       = !cmd_ready;
        mc_ce      = !bus_active;
        mc_oe      = !((state_q == StStrobe) && !write_q);
        mc_we      = !((state_q == StStrobe) && write_q);
        mc_dout_oe = bus_active && write_q;
        mc_add     = add_q;
        mc_dout    = dout_q;
        rsp_data   = rsp_data_q;
        rsp_valid  = rsp_valid_q;
    end

endmodule

// File: doc/mc_bus_master.md
# mc_bus_master

Initiator for the asynchronous SRAM-style memory-controller bus (chip enable, output enable, write enable, address, 16-bit data) that the Bus Pirate FPGA exposes as a responder. Accepts single read/write commands on a valid/ready interface and generates correctly sequenced bus cycles with parameterised setup/strobe/hold phases. Read data returns on a one-cycle response strobe. Used as the synthesizable bus driver for board-to-board links and as the traffic source in the FIFO/dispatch regression benches.

## Interface
- MC_DATA_WIDTH, 16, data bus width
- MC_ADD_WIDTH, 6, address bus width
- SETUP_CYCLES, 2, clocks of address/CE valid before strobe (≥1)
- STROBE_CYCLES, 4, clocks of OE or WE asserted (≥1)
- HOLD_CYCLES, 2, clocks of address/CE/data held after strobe (≥1)
- CNT_WIDTH, 4, phase counter width; every *_CYCLES value ≤ 2^CNT_WIDTH

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_add  in  MC_ADD_WIDTH  target address
- cmd_data  in  MC_DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  MC_DATA_WIDTH  captured read data
- busy  out  1  bus cycle in progress
- mc_ce, mc_oe, mc_we  out  1 each  bus strobes, active-low
- mc_add  out  MC_ADD_WIDTH  bus address
- mc_dout  out  MC_DATA_WIDTH  data to pad
- mc_dout_oe  out  1  pad output enable, 1=drive
- mc_din  in  MC_DATA_WIDTH  data from pad

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN (TURN exists only with macro, see Configuration).
- IDLE: cmd_ready=1, busy=0, mc_ce/mc_oe/mc_we=1, mc_dout_oe=0. On cmd_valid&&cmd_ready: latch cmd_write/cmd_add/cmd_data into mc_add/mc_dout, go SETUP.
- SETUP (SETUP_CYCLES clocks): mc_ce=0, strobes high; mc_dout_oe=1 for writes only. Then STROBE.
- STROBE (STROBE_CYCLES clocks): mc_oe=0 for read, mc_we=0 for write; CE/address/data unchanged. Reads sample mc_din into rsp_data on the rising edge ending the last STROBE cycle. Then HOLD.
- HOLD (HOLD_CYCLES clocks): strobes high, mc_ce=0, mc_add and write data still driven. rsp_valid=1 during first HOLD cycle for reads only. Then IDLE (or TURN).
- cmd_ready=1 only in IDLE; busy = !cmd_ready. Commands are never queued.
- mc_add, mc_dout hold last value in IDLE; rsp_data holds last read value.
- Phase counter loads *_CYCLES-1 on phase entry, decrements, phase exits at 0.
- reset low (any state, incl. mid-strobe): state→IDLE immediately; mc_ce/mc_oe/mc_we=1, mc_dout_oe=0, mc_add=0, mc_dout=0, rsp_data=0, rsp_valid=0, busy=0, cmd_ready=1 after release. Aborted read produces no rsp_valid.

## Timing
- Accept edge N; mc_ce falls in cycle N+1.
- Bus cycle (mc_ce low) = SETUP+STROBE+HOLD clocks (default 8).
- Read latency accept→rsp_valid = SETUP+STROBE+1 cycles (default 7).
- cmd_ready returns the cycle after the last HOLD cycle; minimum mc_ce high gap between back-to-back commands = 1 clock.
- mc_dout_oe never high while mc_oe=0; it rises with mc_ce and falls with mc_ce.

## Configuration
- MC_BUS_MASTER_TURNAROUND_EN defined: after a read's HOLD, enter TURN for 2 clocks (all strobes high, mc_dout_oe=0, cmd_ready=0, busy=1) before IDLE, guaranteeing ≥3 idle clocks for responder output-driver turnaround. Writes unaffected.
- Undefined: TURN state absent; reads return directly to IDLE, same 1-clock gap as writes.

## Test plan
- Write add=0x00 data=0xA5A5, defaults → mc_ce low 8 clocks, mc_we low clocks 3–6 of them, mc_dout=0xA5A5 and mc_dout_oe=1 for all 8, no rsp_valid.
- Read add=0x19 with mc_din=0x1234 through strobe → rsp_valid one cycle, 7 cycles after accept, rsp_data=0x1234, mc_oe low 4 clocks, mc_dout_oe=0 throughout.
- Read with mc_din changing 0x1234→0xBEEF on first HOLD cycle → rsp_data=0x1234.
- Back-to-back writes with cmd_valid held high → mc_ce high exactly 1 clock between cycles; without macro read→write also 1 clock; with macro read→write 3 clocks.
- reset low during 2nd STROBE cycle of a read → same cycle strobes high, mc_dout_oe=0, no rsp_valid; after release a write completes normally.
- SETUP=HOLD=STROBE=1 → mc_ce low exactly 3 clocks, read latency 3 cycles.
